// File: rtl/vga_screen_sequencer.sv
// Frame-synchronous screen sequencer for the VGA path: splash/menu/play/save/result
// flow, per-frame pad snapshot, round scoring and the save req/ack handshake.
module vga_screen_sequencer #(
  parameter int ROUND_FRAMES = 1800,
  parameter int HIT_MAX      = 40,
  parameter int SCORE_MAX    = 255
) (
  input  logic        iRST_n,
  input  logic        iVGA_CLK,
  input  logic        iVS,
  input  logic [31:0] controller,
  input  logic [31:0] sensor_input,
  input  logic        save_ack,
  output logic [31:0] screen,
  output logic [20:0] sensor_snapshot,
  output logic [2:0]  pad_hit,
  output logic [7:0]  score,
  output logic [15:0] frames_left,
  output logic [31:0] sensor_input_to_save,
  output logic [31:0] save_signal
);

  typedef enum logic [2:0] {SPLASH, MENU, PLAY, SAVE, RESULT} state_t;

  localparam logic [15:0] ROUND_INIT = 16'(ROUND_FRAMES);
  localparam logic [7:0]  HIT_LIM    = 8'(HIT_MAX);
  localparam logic [8:0]  SCORE_LIM  = 9'(SCORE_MAX);

  state_t     state;
  logic       vs_q;
  logic       frame_tick;
  logic       save_req;
  logic       mode;
  logic [1:0] screen_code;
  logic [3:0] btn_prev;
  logic [3:0] press;
  logic [2:0] next_hit;
  logic [2:0] new_hit;
  logic [1:0] new_hit_cnt;
  logic [7:0] score_next;
  logic [8:0] record;
  logic       unused_bits;

  function automatic logic is_hit(input logic [6:0] v);
    return (v != 7'd0) && ({1'b0, v} < HIT_LIM);
  endfunction

  // Sum is formed one bit wider than the score so a wrap can never slip past the clamp.
  function automatic logic [7:0] sat_score(input logic [7:0] cur, input logic [1:0] add);
    logic [8:0] sum;
    sum = {1'b0, cur} + {7'd0, add};
    return (sum > SCORE_LIM) ? SCORE_LIM[7:0] : sum[7:0];
  endfunction

  assign frame_tick = vs_q & ~iVS;
  assign press      = controller[4:1] & ~btn_prev;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pad_hit[i]  = is_hit(sensor_snapshot[7*i +: 7]);
      next_hit[i] = is_hit(sensor_input[7*i +: 7]);
    end
  end

  // A hit scores only on its rising edge between consecutive snapshots.
  assign new_hit     = next_hit & ~pad_hit;
  assign new_hit_cnt = {1'b0, new_hit[0]} + {1'b0, new_hit[1]} + {1'b0, new_hit[2]};
  assign score_next  = sat_score(score, new_hit_cnt);

  assign screen               = {30'd0, screen_code};
  assign save_signal          = {31'd0, save_req};
  assign sensor_input_to_save = {23'd0, record};
  assign unused_bits          = ^{controller[31:5], controller[0], sensor_input[31:21]};

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state           <= SPLASH;
      screen_code     <= 2'd0;
      vs_q            <= 1'b0;
      btn_prev        <= 4'd0;
      sensor_snapshot <= 21'd0;
      score           <= 8'd0;
      frames_left     <= 16'd0;
      record          <= 9'd0;
      save_req        <= 1'b0;
      mode            <= 1'b0;
    end else begin
      vs_q <= iVS;

      // The handshake runs on the pixel clock, independent of frame ticks.
      if (state == SAVE && save_ack) begin
        save_req    <= 1'b0;
        state       <= RESULT;
        screen_code <= 2'd3;
      end

      if (frame_tick) begin
        sensor_snapshot <= sensor_input[20:0];
        btn_prev        <= controller[4:1];
        unique case (state)
          SPLASH: begin
            if (|press) begin
              state       <= MENU;
              screen_code <= 2'd1;
            end
          end
          MENU: begin
            if (press[1] || press[2]) begin
              state       <= PLAY;
              screen_code <= 2'd2;
              mode        <= ~press[1];
              score       <= 8'd0;
              frames_left <= ROUND_INIT;
            end else if (press[3]) begin
              state       <= RESULT;
              screen_code <= 2'd3;
            end
          end
          PLAY: begin
            if (press[0]) begin
              state       <= MENU;
              screen_code <= 2'd1;
            end else begin
              score       <= score_next;
              frames_left <= frames_left - 16'd1;
              if (frames_left == 16'd1) begin
                state    <= SAVE;
                save_req <= 1'b1;
                record   <= {mode, score_next};
              end
            end
          end
          RESULT: begin
            if (press[0]) begin
              state       <= MENU;
              screen_code <= 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Randomised and directed bench for vga_screen_sequencer against a frame-level model.
module tb_vga_screen_sequencer;

  localparam int ROUND = 180;
  localparam int HMAX  = 40;
  localparam int S_SPLASH = 0, S_MENU = 1, S_PLAY = 2, S_SAVE = 3, S_RESULT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        save_ack = 1'b0;
  logic [31:0] controller = 32'd0;
  logic [31:0] sensor = 32'd0;
  logic [31:0] screen;
  logic [20:0] sensor_snapshot;
  logic [2:0]  pad_hit;
  logic [7:0]  score;
  logic [15:0] frames_left;
  logic [31:0] sensor_input_to_save;
  logic [31:0] save_signal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_screen_sequencer #(.ROUND_FRAMES(ROUND), .HIT_MAX(HMAX), .SCORE_MAX(255)) dut (
    .iRST_n(rst_n),
    .iVGA_CLK(clk),
    .iVS(vs),
    .controller(controller),
    .sensor_input(sensor),
    .save_ack(save_ack),
    .screen(screen),
    .sensor_snapshot(sensor_snapshot),
    .pad_hit(pad_hit),
    .score(score),
    .frames_left(frames_left),
    .sensor_input_to_save(sensor_input_to_save),
    .save_signal(save_signal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pads(input int a, input int b, input int c);
    return {11'd0, 7'(c), 7'(b), 7'(a)};
  endfunction

  // ---------------- behavioural model (one step per clock) ----------------
  int         m_st, m_score, m_frames, m_mode, m_rec, m_req;
  logic [20:0] m_snap;
  logic [3:0]  m_prev;
  logic        m_vs;

  function automatic bit hit(input logic [20:0] s, input int i);
    int v;
    v = int'(s[7*i +: 7]);
    return (v >= 1) && (v < HMAX);
  endfunction

  function automatic int screen_of(input int st);
    case (st)
      S_SPLASH: return 0;
      S_MENU:   return 1;
      S_RESULT: return 3;
      default:  return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_SPLASH; m_score = 0; m_frames = 0; m_mode = 0; m_rec = 0; m_req = 0;
    m_snap = '0; m_prev = '0; m_vs = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    int st0, n;
    logic [3:0] pr;
    tick = m_vs && !vs;
    m_vs = vs;
    st0 = m_st;
    if (st0 == S_SAVE && save_ack) begin
      m_req = 0;
      m_st = S_RESULT;
    end
    if (tick) begin
      pr = controller[4:1] & ~m_prev;
      m_prev = controller[4:1];
      case (st0)
        S_SPLASH: if (pr != 0) m_st = S_MENU;
        S_MENU: begin
          if (pr[1] || pr[2]) begin
            m_st = S_PLAY; m_mode = pr[1] ? 0 : 1; m_score = 0; m_frames = ROUND;
          end else if (pr[3]) m_st = S_RESULT;
        end
        S_PLAY: begin
          if (pr[0]) m_st = S_MENU;
          else begin
            n = 0;
            for (int i = 0; i < 3; i++)
              if (hit(sensor[20:0], i) && !hit(m_snap, i)) n++;
            m_score = (m_score + n > 255) ? 255 : m_score + n;
            m_frames--;
            if (m_frames == 0) begin
              m_st = S_SAVE; m_req = 1; m_rec = m_mode * 256 + m_score;
            end
          end
        end
        S_RESULT: if (pr[0]) m_st = S_MENU;
        default: ;
      endcase
      m_snap = sensor[20:0];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    logic [2:0] eh;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) eh[i] = hit(m_snap, i);
    chk("screen", screen, 32'(screen_of(m_st)));
    chk("snapshot", {11'd0, sensor_snapshot}, {11'd0, m_snap});
    chk("pad_hit", {29'd0, pad_hit}, {29'd0, eh});
    chk("score", {24'd0, score}, 32'(m_score));
    chk("frames_left", {16'd0, frames_left}, 32'(m_frames));
    chk("save_record", sensor_input_to_save, 32'(m_rec));
    chk("save_signal", save_signal, 32'(m_req));
  end

  // One frame: vs high for a few cycles, then low; the tick edge is the posedge
  // right after vs falls. Returns just after that edge.
  task automatic frame(input logic [31:0] c, input logic [31:0] s);
    @(negedge clk); vs = 1'b1;
    repeat (3) @(negedge clk);
    controller = c; sensor = s; vs = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] c, s;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_screen", screen, 32'd0);
    chk("rst_save", save_signal, 32'd0);
    chk("rst_record", sensor_input_to_save, 32'd0);
    chk("rst_frames", {16'd0, frames_left}, 32'd0);

    // Idle frames stay on splash; a held button moves exactly once.
    repeat (3) frame(32'd0, 32'd0);
    chk("t1_idle_screen", screen, 32'd0);
    chk("t1_idle_score", {24'd0, score}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      frame(32'd2, 32'd0);
      chk("t1_menu", screen, 32'd1);
    end

    // Simultaneous A+B selects mode A.
    frame(32'd12, 32'd0);
    chk("t2_play", screen, 32'd2);
    chk("t2_frames", {16'd0, frames_left}, 32'(ROUND));
    chk("t2_score", {24'd0, score}, 32'd0);

    frame(32'd0, pads(0, 10, 0));  chk("t3_s1", {24'd0, score}, 32'd1);
    frame(32'd0, pads(0, 10, 0));  chk("t3_s2", {24'd0, score}, 32'd1);
    frame(32'd0, pads(5, 10, 50)); chk("t3_s3", {24'd0, score}, 32'd2);
    frame(32'd0, pads(5, 0, 5));   chk("t3_s4", {24'd0, score}, 32'd3);
    chk("t3_frames", {16'd0, frames_left}, 32'(ROUND - 4));
    n = 0;
    while (!save_signal[0] && n < 400) begin frame(32'd0, 32'd0); n++; end
    chk("t3_save_req", save_signal, 32'd1);
    chk("t3_record", sensor_input_to_save, 32'h003);

    // Request held until ack is sampled.
    n = 0;
    for (int i = 0; i < 40 && save_signal[0]; i++) begin
      n++;
      @(negedge clk) save_ack = (i == 10);
      @(posedge clk); #2;
    end
    @(negedge clk) save_ack = 1'b0;
    chk("t4_req_cycles", 32'(n), 32'd11);
    chk("t4_result", screen, 32'd3);
    frame(32'd16, 32'd0);
    chk("t4_result_hold", screen, 32'd3);
    frame(32'd2, 32'd0);
    chk("t4_back", screen, 32'd1);

    // Mode B round driving the score into saturation; ack already high at entry.
    frame(32'd8, 32'd0);
    save_ack = 1'b1;
    for (int i = 0; i < 400 && !save_signal[0]; i++) begin
      s = (i == 0) ? pads(5, 5, 0) : ((i % 2 == 0) ? pads(5, 5, 5) : 32'd0);
      frame(32'd0, s);
      if (i == 168) chk("t5_near", {24'd0, score}, 32'd254);
      if (i == 170) chk("t5_sat", {24'd0, score}, 32'd255);
    end
    chk("t5_final", {24'd0, score}, 32'd255);
    chk("t5_record", sensor_input_to_save, 32'h1FF);
    chk("t5_req", save_signal, 32'd1);
    @(posedge clk); #2;
    chk("t5_req_1cyc", save_signal, 32'd0);
    chk("t5_result", screen, 32'd3);
    save_ack = 1'b0;

    // Reset while the save request is up.
    frame(32'd2, 32'd0);
    frame(32'd4, 32'd0);
    n = 0;
    while (!save_signal[0] && n < 400) begin frame(32'd0, 32'd0); n++; end
    repeat (3) @(posedge clk);
    #2;
    chk("t6_req_before", save_signal, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_save", save_signal, 32'd0);
    chk("t6_async_screen", screen, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back press on the expiry tick wins.
    frame(32'd2, 32'd0);
    frame(32'd0, 32'd0);
    frame(32'd4, 32'd0);
    n = 0;
    while (frames_left != 16'd1 && n < 400) begin frame(32'd0, pads(7, 0, 0)); n++; end
    frame(32'd2, pads(0, 0, 0));
    chk("t6_abort_screen", screen, 32'd1);
    chk("t6_abort_save", save_signal, 32'd0);

    // Random traffic, including ignored upper bits.
    for (int i = 0; i < 300; i++) begin
      c = $urandom;
      c[1] = ($urandom_range(0, 7) == 0);
      s = $urandom;
      s[20:0] = pads($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50));
      save_ack = 1'($urandom_range(0, 1));
      frame(c, s);
    end
    save_ack = 1'b0;
    repeat (4) @(posedge clk);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
